// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : UART receiver core. Synchronizes the asynchronous serial
//                line, detects the start bit, samples each bit at its centre
//                using a programmable per-bit clock divisor, checks optional
//                even/odd parity and the stop bit, and delivers good bytes
//                into a single-entry holding register with ready/valid
//                hand-off.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_SYNC_STAGES  flops in the rx_in synchronizer (legal 2..3)
//  Ports
//    clk          in   clock, rising edge
//    rst_n        in   synchronous active-low reset
//    rx_in        in   asynchronous serial line, idle high
//    uart_enable  in   receiver enable
//    uart_mode    in   [1:0] parity 00/11 none, 01 even, 10 odd;
//                      [2] data bits 0 = 8, 1 = 7
//    uart_rate    in   clock cycles per bit (clamped to >= 4)
//    rx_data      out  received byte (bit 7 is 0 in 7-bit mode)
//    rx_valid     out  holding register full
//    rx_ready     in   consumer accepts when rx_valid & rx_ready
//    rx_overrun   out  1-cycle pulse, good frame dropped (holding reg full)
//    uart_busy    out  frame reception in progress
//    uart_error   out  1-cycle pulses: [0] parity, [1] framing
//    update_ok    out  receiver idle, baud-rate commit is safe
// ============================================================================
module uart_rx_core #(
  parameter int CLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  input  logic        uart_enable,
  input  logic [2:0]  uart_mode,
  input  logic [15:0] uart_rate,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  output logic        uart_busy,
  output logic [1:0]  uart_error,
  output logic        update_ok
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  localparam logic [15:0] c_MIN_DIV = 16'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [CLK_SYNC_STAGES-1:0] r_sync;
  logic                       r_rxs_prev;
  logic [2:0]                 r_state;
  logic [15:0]                r_cnt;
  logic [15:0]                r_div;
  logic [2:0]                 r_mode;
  logic [2:0]                 r_bit_idx;
  logic [7:0]                 r_shift;
  logic                       r_par_acc;
  logic                       r_par_err;
  logic [7:0]                 r_data;
  logic                       r_valid;
  logic                       r_overrun;
  logic                       r_busy;
  logic [1:0]                 r_error;
  logic                       r_update_ok;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic        w_rxs;
  logic        w_fall;
  logic [15:0] w_div_eff;
  logic        w_tick;
  logic        w_par_en;
  logic        w_par_odd;
  logic [2:0]  w_last_bit;
  logic        w_good;
  logic        w_pop;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_div_nxt;
  logic [2:0]  w_mode_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_par_acc_nxt;
  logic        w_par_err_nxt;
  logic        w_stop_sample;
  logic        w_frame_err;

  // --------------------------------------------------------------------------
  // Input synchronizer. Resets to all ones so that reset release never looks
  // like a start-bit falling edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[CLK_SYNC_STAGES-2:0], rx_in};
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_rxs = r_sync[CLK_SYNC_STAGES-1];

  // The previous-value register is updated every cycle regardless of state,
  // so an edge arriving right as the FSM returns to IDLE is still caught.
  assign w_fall = r_rxs_prev & ~w_rxs;

  assign w_div_eff  = (uart_rate < c_MIN_DIV) ? c_MIN_DIV : uart_rate;
  assign w_tick     = (r_cnt == 16'd0);
  assign w_par_en   = (r_mode[1:0] == 2'b01) || (r_mode[1:0] == 2'b10);
  assign w_par_odd  = (r_mode[1:0] == 2'b10);
  assign w_last_bit = r_mode[2] ? 3'd6 : 3'd7;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_mode_nxt    = r_mode;
    w_bit_nxt     = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_acc_nxt = r_par_acc;
    w_par_err_nxt = r_par_err;
    w_stop_sample = 1'b0;
    w_frame_err   = 1'b0;

    if (!uart_enable) begin
      // Disabling aborts any frame silently; holding register untouched.
      w_state_nxt = c_IDLE;
      w_cnt_nxt   = 16'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_fall) begin
            // Divisor and mode are frozen for the whole frame; the first
            // sample lands half a bit in, at the centre of the start bit.
            w_state_nxt = c_START;
            w_div_nxt   = w_div_eff;
            w_mode_nxt  = uart_mode;
            w_cnt_nxt   = (w_div_eff >> 1) - 16'd1;
          end
        end

        default: begin
          if (!w_tick) begin
            w_cnt_nxt = r_cnt - 16'd1;
          end else begin
            w_cnt_nxt = r_div - 16'd1;
            case (r_state)
              c_START: begin
                if (!w_rxs) begin
                  w_state_nxt   = c_DATA;
                  w_bit_nxt     = 3'd0;
                  w_shift_nxt   = 8'h00;
                  w_par_acc_nxt = 1'b0;
                  w_par_err_nxt = 1'b0;
                end else begin
                  // Line back high at mid start bit: treat as a glitch.
                  w_state_nxt = c_IDLE;
                  w_cnt_nxt   = 16'd0;
                end
              end

              c_DATA: begin
                w_shift_nxt[r_bit_idx] = w_rxs;
                w_par_acc_nxt          = r_par_acc ^ w_rxs;
                w_bit_nxt              = r_bit_idx + 3'd1;
                if (r_bit_idx == w_last_bit) begin
                  w_state_nxt = w_par_en ? c_PARITY : c_STOP;
                end
              end

              c_PARITY: begin
                // Even: total XOR must be 0; odd: must be 1.
                w_par_err_nxt = r_par_acc ^ w_rxs ^ w_par_odd;
                w_state_nxt   = c_STOP;
              end

              c_STOP: begin
                w_stop_sample = 1'b1;
                w_frame_err   = ~w_rxs;
                w_state_nxt   = c_IDLE;
                w_cnt_nxt     = 16'd0;
              end

              default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 16'd0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= 16'd0;
      r_div     <= 16'd0;
      r_mode    <= 3'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_par_acc <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_mode    <= w_mode_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_acc <= w_par_acc_nxt;
      r_par_err <= w_par_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Holding register, status pulses and status levels
  // --------------------------------------------------------------------------
  assign w_good = w_stop_sample & ~w_frame_err & ~r_par_err;
  assign w_pop  = r_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_error     <= 2'b00;
      r_busy      <= 1'b0;
      r_update_ok <= 1'b0;
    end else begin
      r_error   <= w_stop_sample ? {w_frame_err, r_par_err} : 2'b00;
      r_overrun <= w_good & r_valid & ~rx_ready;

      // A push in the same cycle as a pop wins: the new byte replaces the
      // one being consumed and valid stays set.
      if (w_good && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end

      // Derived from the next state so update_ok is already low on the
      // first cycle of START.
      r_busy      <= (w_state_nxt != c_IDLE);
      r_update_ok <= (w_state_nxt == c_IDLE);
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign rx_overrun = r_overrun;
  assign uart_busy  = r_busy;
  assign uart_error = r_error;
  assign update_ok  = r_update_ok;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Directed self-checking bench for uart_rx_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  logic        clk;
  logic        rst_n;
  logic        rx_in;
  logic        uart_enable;
  logic [2:0]  uart_mode;
  logic [15:0] uart_rate;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overrun;
  logic        uart_busy;
  logic [1:0]  uart_error;
  logic        update_ok;

  int total = 0;
  int bad   = 0;

  int         n_par = 0;
  int         n_fr  = 0;
  int         n_ovr = 0;
  logic [1:0] last_err = 2'b00;

  uart_rx_core #(.CLK_SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .uart_enable (uart_enable),
    .uart_mode   (uart_mode),
    .uart_rate   (uart_rate),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .uart_busy   (uart_busy),
    .uart_error  (uart_error),
    .update_ok   (update_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (uart_error != 2'b00) last_err = uart_error;
    if (uart_error[0]) n_par = n_par + 1;
    if (uart_error[1]) n_fr  = n_fr + 1;
    if (rx_overrun)    n_ovr = n_ovr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame; call at posedge+1, returns at posedge+1.
  // par < 0 means no parity bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                            input logic stop, input int blen);
    rx_in = 1'b0;
    repeat (blen) @(posedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      rx_in = d[i];
      repeat (blen) @(posedge clk);
      #1;
    end
    if (par >= 0) begin
      rx_in = par[0];
      repeat (blen) @(posedge clk);
      #1;
    end
    rx_in = stop;
    repeat (blen) @(posedge clk);
    #1;
    rx_in = 1'b1;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  int viol;
  int np, nf, no;

  initial begin
    rst_n       = 1'b0;
    rx_in       = 1'b1;
    uart_enable = 1'b1;
    uart_mode   = 3'b000;
    uart_rate   = 16'd16;
    rx_ready    = 1'b0;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    32'(uart_busy),  32'd0);
    chk("rst_updok",   32'(update_ok),  32'd0);
    chk("rst_valid",   32'(rx_valid),   32'd0);
    chk("rst_data",    32'(rx_data),    32'd0);
    chk("rst_err",     32'(uart_error), 32'd0);
    chk("rst_ovr",     32'(rx_overrun), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_updok",   32'(update_ok),  32'd1);
    chk("rel_busy",    32'(uart_busy),  32'd0);

    // ---------------- basic 8N1 0xA5, latency ----------------
    repeat (2) @(posedge clk);
    #1;
    viol = 0;
    fork
      send_frame(8'hA5, 8, -1, 1'b1, 16);
    join_none
    for (int k = 1; k <= 155; k++) begin
      @(posedge clk);
      #1;
      if (k >= 3 && k <= 154) begin
        if (uart_busy !== 1'b1 || update_ok !== 1'b0) viol = viol + 1;
      end
      if (k == 154) chk("basic_valid_early", 32'(rx_valid), 32'd0);
    end
    chk("basic_busy_window", 32'(viol),      32'd0);
    chk("basic_valid",       32'(rx_valid),  32'd1);
    chk("basic_data",        32'(rx_data),   32'hA5);
    chk("basic_idle_busy",   32'(uart_busy), 32'd0);
    chk("basic_idle_updok",  32'(update_ok), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    pop();
    chk("pop_valid", 32'(rx_valid), 32'd0);
    chk("pop_data",  32'(rx_data),  32'hA5);

    // ---------------- even parity error ----------------
    uart_mode = 3'b001;
    np = n_par; nf = n_fr;
    @(posedge clk);
    #1;
    send_frame(8'h03, 8, 1, 1'b1, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("par_even_cnt",    32'(n_par - np), 32'd1);
    chk("par_even_fr",     32'(n_fr - nf),  32'd0);
    chk("par_even_val",    32'(last_err),   32'd1);
    chk("par_even_nopush", 32'(rx_valid),   32'd0);

    // ---------------- odd parity ok ----------------
    uart_mode = 3'b010;
    np = n_par;
    @(posedge clk);
    #1;
    send_frame(8'h03, 8, 1, 1'b1, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("par_odd_cnt",   32'(n_par - np), 32'd0);
    chk("par_odd_valid", 32'(rx_valid),   32'd1);
    chk("par_odd_data",  32'(rx_data),    32'h03);
    pop();

    // ---------------- framing error ----------------
    uart_mode = 3'b000;
    nf = n_fr;
    @(posedge clk);
    #1;
    send_frame(8'h5A, 8, -1, 1'b0, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("frame_cnt",   32'(n_fr - nf), 32'd1);
    chk("frame_val",   32'(last_err),  32'd2);
    chk("frame_valid", 32'(rx_valid),  32'd0);

    // ---------------- overrun ----------------
    uart_rate = 16'd4;
    no = n_ovr;
    @(posedge clk);
    #1;
    send_frame(8'h11, 8, -1, 1'b1, 4);
    send_frame(8'h22, 8, -1, 1'b1, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_data",  32'(rx_data),     32'h11);
    chk("ovr_valid", 32'(rx_valid),    32'd1);
    chk("ovr_cnt",   32'(n_ovr - no),  32'd1);
    pop();
    repeat (4) @(posedge clk);
    #1;

    // Simultaneous pop and push: ready high only in the stop-sample cycle.
    send_frame(8'h11, 8, -1, 1'b1, 4);
    no = n_ovr;
    fork
      send_frame(8'h22, 8, -1, 1'b1, 4);
    join_none
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      if (k == 40) rx_ready = 1'b1;
      if (k == 41) rx_ready = 1'b0;
    end
    chk("simul_data",  32'(rx_data),    32'h22);
    chk("simul_valid", 32'(rx_valid),   32'd1);
    chk("simul_ovr",   32'(n_ovr - no), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    pop();

    // ---------------- glitch ----------------
    uart_rate = 16'd16;
    np = n_par; nf = n_fr;
    @(posedge clk);
    #1;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_start", 32'(uart_busy), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_idle",  32'(uart_busy),             32'd0);
    chk("glitch_err",   32'((n_par - np) + (n_fr - nf)), 32'd0);
    chk("glitch_valid", 32'(rx_valid),              32'd0);

    // ---------------- enable abort ----------------
    np = n_par; nf = n_fr; no = n_ovr;
    @(posedge clk);
    #1;
    fork
      send_frame(8'hC3, 8, -1, 1'b1, 16);
    join_none
    repeat (60) @(posedge clk);
    #1;
    uart_enable = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy",  32'(uart_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_updok", 32'(update_ok), 32'd1);
    repeat (110) @(posedge clk);
    #1;
    uart_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_nopush", 32'(rx_valid), 32'd0);
    chk("abort_noerr",  32'((n_par - np) + (n_fr - nf) + (n_ovr - no)), 32'd0);

    // ---------------- rate clamp ----------------
    uart_rate = 16'd1;
    @(posedge clk);
    #1;
    send_frame(8'h3C, 8, -1, 1'b1, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("clamp_valid", 32'(rx_valid), 32'd1);
    chk("clamp_data",  32'(rx_data),  32'h3C);
    pop();

    // ---------------- 7-bit mode, rate change mid-frame ----------------
    uart_rate = 16'd16;
    uart_mode = 3'b100;
    @(posedge clk);
    #1;
    fork
      send_frame(8'hD5, 7, -1, 1'b1, 16);
    join_none
    repeat (50) @(posedge clk);
    #1;
    uart_rate = 16'd5;
    repeat (120) @(posedge clk);
    #1;
    chk("bit7_valid", 32'(rx_valid), 32'd1);
    chk("bit7_data",  32'(rx_data),  32'h55);
    uart_rate = 16'd16;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
